// File: rtl/gauss_decim2_if.sv
// Stream bundle for the Gaussian pyramid 2:1 REDUCE stage: a stall-qualified input beat and a pulsed output beat.
interface gauss_decim2_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  stall;
    logic [DATA_WIDTH-1:0] inp_frame;
    logic [DATA_WIDTH-1:0] out_frame;
    logic                  out_valid;
    logic                  out_last;

    modport master (
        output stall,
        output inp_frame,
        input  out_frame,
        input  out_valid,
        input  out_last
    );

    modport slave (
        input  stall,
        input  inp_frame,
        output out_frame,
        output out_valid,
        output out_last
    );
endinterface

// File: rtl/gauss_decim2.sv
// Gaussian pyramid REDUCE: keeps even rows/columns and repacks two input beats into one output beat.
// Optional macro GAUSS_DECIM2_HAVG_EN replaces column selection with a rounded horizontal pair average.
module gauss_decim2 #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int LEAD_BEATS      = 1,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
    input  logic             clk,
    input  logic             aresetn,
    gauss_decim2_if.slave    bus
);
    localparam int COLS   = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int HALF   = PIXELS_PER_BEAT / 2;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W  = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;
    localparam int SKIP_W = (LEAD_BEATS > 1) ? $clog2(LEAD_BEATS) : 1;

    localparam logic [0:0] ST_SKIP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [0:0] ST_INIT = (LEAD_BEATS == 0) ? ST_RUN : ST_SKIP;

    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(IMAGE_DIM - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMAGE_DIM - 2);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(LEAD_BEATS - 1);

    logic [0:0]               state_q, state_d;
    logic [SKIP_W-1:0]        skip_q, skip_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [DATA_WIDTH/2-1:0]  half_q, half_d;
    logic [DATA_WIDTH-1:0]    outFrame_q, outFrame_d;
    logic                     outValid_q, outValid_d;
    logic                     outLast_q, outLast_d;
    logic [DATA_WIDTH/2-1:0]  pick;
`ifdef GAUSS_DECIM2_HAVG_EN
    logic [8:0]               pairSum;
`endif

    // Half-width view of the incoming beat: one output pixel per input pixel pair.
    always_comb begin
        pick = '0;
`ifdef GAUSS_DECIM2_HAVG_EN
        pairSum = '0;
`endif
        for (int k = 0; k < HALF; k++) begin
`ifdef GAUSS_DECIM2_HAVG_EN
            pairSum = {1'b0, bus.inp_frame[16*k +: 8]} + {1'b0, bus.inp_frame[16*k+8 +: 8]} + 9'd1;
            pick[8*k +: 8] = pairSum[8:1];
`else
            pick[8*k +: 8] = bus.inp_frame[16*k +: 8];
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        col_d      = col_q;
        row_d      = row_q;
        half_d     = half_q;
        outFrame_d = outFrame_q;
        outValid_d = 1'b0;
        outLast_d  = 1'b0;
        if (!bus.stall) begin
            if (state_q == ST_SKIP) begin
                if (skip_q == SKIP_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    skip_d = skip_q + 1'b1;
                end
            end else begin
                if (!row_q[0]) begin
                    if (!col_q[0]) begin
                        half_d = pick;
                    end else begin
                        outFrame_d = {pick, half_q};
                        outValid_d = 1'b1;
                        outLast_d  = (row_q == ROW_LAST) && (col_q == COL_MAX);
                    end
                end
                // Counters wrap explicitly since IMAGE_DIM need not be a power of two.
                if (col_q == COL_MAX) begin
                    col_d = '0;
                    row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= ST_INIT;
            skip_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            half_q     <= '0;
            outFrame_q <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            col_q      <= col_d;
            row_q      <= row_d;
            half_q     <= half_d;
            outFrame_q <= outFrame_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
        end
    end

    assign bus.out_frame = outFrame_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_last  = outLast_q;
endmodule

// File: tb/tb_gauss_decim2.sv
// Scoreboard bench for gauss_decim2: random beats and stalls, expectations from a frame-position model.
module tb_gauss_decim2;
    localparam int PPB  = 16;
    localparam int DIM  = 512;
    localparam int LEAD = 1;
    localparam int DW   = 8 * PPB;
    localparam int COLS = DIM / PPB;
    localparam int HALF = PPB / 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    gauss_decim2_if #(.DATA_WIDTH(DW)) bus();

    gauss_decim2 #(
        .PIXELS_PER_BEAT(PPB),
        .IMAGE_DIM(DIM),
        .LEAD_BEATS(LEAD),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .bus(bus)
    );

    exp_t          expQ[$];
    int            checks = 0;
    int            errors = 0;
    int            pulseCount = 0;
    int            lastCount = 0;
    int            lastPulseIdx = 0;
    longint        beatIdx = 0;
    logic [DW-1:0] prevBeat = '0;
    logic [DW-1:0] firstOut = '0;
    logic          prevValid = 1'b0;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Output pixel k comes from pair k of the first beat, or pair k-HALF of the second.
    function automatic logic [DW-1:0] reduce(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic [DW-1:0] src;
        int j;
        int p0;
        int p1;
        r = '0;
        for (int k = 0; k < PPB; k++) begin
            src = (k < HALF) ? a : b;
            j = 2 * (k % HALF);
            p0 = int'(src[8*j +: 8]);
            p1 = int'(src[8*(j+1) +: 8]);
`ifdef GAUSS_DECIM2_HAVG_EN
            r[8*k +: 8] = 8'((p0 + p1 + 1) / 2);
`else
            r[8*k +: 8] = 8'(p0);
            if (p1 < 0) r = '0;
`endif
        end
        return r;
    endfunction

    task automatic modelAccept(input logic [DW-1:0] d);
        longint idx;
        longint pos;
        int row;
        int col;
        if (beatIdx >= LEAD) begin
            idx = beatIdx - LEAD;
            pos = idx % (COLS * DIM);
            row = int'(pos / COLS);
            col = int'(pos % COLS);
            if (row % 2 == 0) begin
                if (col % 2 == 0) prevBeat = d;
                else expQ.push_back('{reduce(prevBeat, d), (row == DIM - 2) && (col == COLS - 1)});
            end
        end
        beatIdx++;
    endtask

    task automatic applyStimulus(input logic s, input logic [DW-1:0] d);
        bus.stall = s;
        bus.inp_frame = d;
        @(posedge clk);
        if (aresetn && !s) modelAccept(d);
        #1;
    endtask

    function automatic logic [DW-1:0] randomBeat();
        logic [DW-1:0] r;
        for (int w = 0; w < DW / 32; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] beatFor(input int r, input int c);
        logic [DW-1:0] b;
        b = '0;
        for (int i = 0; i < PPB; i++) begin
            if (r == 1) b[8*i +: 8] = 8'hAA;
            else b[8*i +: 8] = 8'((16 * c + i) & 8'hFF);
        end
        if (r > 2) b = randomBeat();
        return b;
    endfunction

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            pulseCount++;
            checkOutput("pulse_width", {{(DW-1){1'b0}}, prevValid}, '0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got frame %h, want no output", bus.out_frame);
            end else begin
                e = expQ.pop_front();
                checkOutput("out_frame", bus.out_frame, e.data);
                checkOutput("out_last", {{(DW-1){1'b0}}, bus.out_last}, {{(DW-1){1'b0}}, e.last});
            end
            if (bus.out_last === 1'b1) begin
                lastCount++;
                lastPulseIdx = pulseCount;
            end
            if (pulseCount == 1) firstOut = bus.out_frame;
        end
        prevValid = (bus.out_valid === 1'b1);
    end

    initial begin
        logic [DW-1:0] firstWant;
        firstWant = '0;
        for (int k = 0; k < PPB; k++) begin
`ifdef GAUSS_DECIM2_HAVG_EN
            firstWant[8*k +: 8] = 8'(2 * k + 1);
`else
            firstWant[8*k +: 8] = 8'(2 * k);
`endif
        end

        bus.stall = 1'b1;
        bus.inp_frame = '0;
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_frame", bus.out_frame, '0);
        checkOutput("reset_valid", {{(DW-1){1'b0}}, bus.out_valid}, '0);
        checkOutput("reset_last", {{(DW-1){1'b0}}, bus.out_last}, '0);
        aresetn = 1'b1;

        // Lead beat of 0xFF is swallowed; then one full frame with random stalls.
        applyStimulus(1'b0, {DW{1'b1}});
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < COLS; c++) begin
                while ($urandom_range(0, 3) == 0) applyStimulus(1'b1, randomBeat());
                applyStimulus(1'b0, beatFor(r, c));
            end
        end
        applyStimulus(1'b1, '0);
        repeat (4) @(negedge clk);
        checkOutput("first_beat", firstOut, firstWant);
        checkOutput("pulse_count", DW'(pulseCount), DW'((DIM / 2) * (COLS / 2)));
        checkOutput("last_count", DW'(lastCount), DW'(1));
        checkOutput("last_position", DW'(lastPulseIdx), DW'((DIM / 2) * (COLS / 2)));
        checkOutput("drained_frame1", DW'(expQ.size()), '0);

        // Second frame up to mid-row 10, stalling every other cycle.
        for (int r = 0; r < 11; r++) begin
            for (int c = 0; c < ((r == 10) ? 5 : COLS); c++) begin
                applyStimulus(1'b1, randomBeat());
                applyStimulus(1'b0, randomBeat());
            end
        end
        applyStimulus(1'b1, '0);
        @(negedge clk);
        checkOutput("drained_row10", DW'(expQ.size()), '0);

        // Single-cycle reset with half a pair pending.
        bus.stall = 1'b0;
        bus.inp_frame = randomBeat();
        aresetn = 1'b0;
        @(posedge clk);
        beatIdx = 0;
        prevBeat = '0;
        @(negedge clk);
        checkOutput("midreset_frame", bus.out_frame, '0);
        checkOutput("midreset_valid", {{(DW-1){1'b0}}, bus.out_valid}, '0);
        aresetn = 1'b1;
        applyStimulus(1'b0, {DW{1'b1}});
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if ($urandom_range(0, 1) == 0) applyStimulus(1'b1, randomBeat());
                applyStimulus(1'b0, randomBeat());
            end
        end
        applyStimulus(1'b1, '0);
        repeat (4) @(negedge clk);
        checkOutput("drained_final", DW'(expQ.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end
endmodule

// File: doc/gauss_decim2.md
Name: gauss_decim2

Overview:
- Downstream neighbour of the 3x3 Gaussian row-buffer convolution stage.
- Consumes its packed, stall-qualified pixel stream and performs the 2:1 REDUCE step of a Gaussian pyramid: keeps even rows and even columns.
- Repacks two input beats into one full output beat, producing an IMAGE_DIM/2 square image at the same beat width for the next pyramid level.

Parameters:
- PIXELS_PER_BEAT, 16, pixels per beat (8 bits each); must be even.
- IMAGE_DIM, 512, input image width and height in pixels; must be a multiple of 2*PIXELS_PER_BEAT.
- LEAD_BEATS, 1, accepted beats discarded after reset to absorb upstream pipeline latency; 0 is legal.
- DATA_WIDTH, 8*PIXELS_PER_BEAT, beat width.

Ports:
- clk  input  1  single clock, rising edge.
- aresetn  input  1  synchronous active-low reset.
- stall  input  1  1 = no beat this cycle: input ignored, all counters and state frozen.
- inp_frame  input  DATA_WIDTH  input beat; pixel i at bits [8i+:8], lowest index leftmost.
- out_frame  output  DATA_WIDTH  decimated output beat, same packing.
- out_valid  output  1  one-cycle pulse; out_frame holds a new beat.
- out_last  output  1  coincides with out_valid on the final beat of an output frame.

Behaviour:
- Reset (aresetn=0 at posedge): out_frame=0, out_valid=0, out_last=0, col/row counters=0, half-beat register=0, state=SKIP (state=RUN if LEAD_BEATS=0).
- A beat is accepted on each posedge with aresetn=1 and stall=0.
- SKIP state:
  - counts accepted beats.
  - After the LEAD_BEATSth accepted beat, moves to RUN.
  - Skipped beats do not advance col/row counters.
- RUN state: col_counter (0..IMAGE_DIM/PIXELS_PER_BEAT-1) and row_counter (0..IMAGE_DIM-1) advance per accepted beat; col wraps to 0 and increments row; row wraps to 0 at frame end; state stays RUN (no re-skip per frame).
- Odd row_counter: beat accepted, data dropped, no output.
- Even row, even col_counter: the even-index pixels (0,2,..,PPB-2) are packed into the half register as output pixels 0..PPB/2-1.
- Even row, odd col_counter:
  - even-index pixels become output pixels PPB/2..PPB-1.
  - Full beat registered into out_frame on the same edge; out_valid=1 for exactly the following cycle, regardless of stall.
- out_frame holds its value until the next output beat.
- out_last=1 with out_valid on the output beat formed at row IMAGE_DIM-2, col IMAGE_DIM/PPB-1.
- Output rate: one beat per 2 accepted input beats on even rows, none on odd rows. Per frame: (IMAGE_DIM/2)*(IMAGE_DIM/(2*PPB)) beats (4096 at defaults).
- Latency: out_valid asserted the cycle after the second beat of a pair is accepted.
- Stall on the cycle out_valid is high does not extend the pulse.
- Pixel arithmetic: pure selection, no rounding, no saturation (see optional feature).
- Reset mid-frame: all partial state discarded; next accepted beat is treated as a new post-reset stream (SKIP applies again).

Optional Feature:
- Macro GAUSS_DECIM2_HAVG_EN.
- Defined: each output pixel is the horizontal pair average (p[2k]+p[2k+1]+1)>>1. Computed with a 9-bit intermediate; result always fits in 8 bits. Rows are still decimated by selection.
- Undefined: pure even-column selection as above.
- Timing and handshakes are identical either way.

Test Plan:
- Stimulus pattern: pixel i of beat c on row r = (16c+i)&0xFF.
- Reset with LEAD_BEATS=0, no stall, one full frame -> 4096 out_valid pulses. First out_frame pixels = 0,2,4,...,30. out_last only on pulse 4096.
- LEAD_BEATS=1, first beat all 0xFF then the pattern -> 0xFF never appears on the output. First output beat = 0,2,...,30.
- Assert stall every other cycle during a row -> out_frame sequence identical to the no-stall run. No out_valid on frozen pairs; pulses never exceed 1 cycle.
- Row 1 driven with all 0xAA -> no out_valid during row 1. Next output is row 2 data.
- Assert aresetn=0 for one cycle mid-row 10 -> outputs 0 the next cycle. Half-beat state discarded. Next two beats form the first output beat.
- With GAUSS_DECIM2_HAVG_EN, inputs p0=0xFF and p1=0xFE -> output pixel 0 = 0xFF. Pattern frame -> first beat = 1,3,5,...,31.
